// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencing controller: steps the shared-memory datapath through
// fetch/decode/execute states, with a memory-ready timeout and illegal-opcode flag.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] Opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state_out,
    output logic       illegal_op,
    output logic       mem_err
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Last counter value before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;
    logic       memerr_q, memerr_d;
    logic       memWait;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_FETCH;
            cnt_q     <= 8'd0;
            illegal_q <= 1'b0;
            memerr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            memerr_q  <= memerr_d;
        end
    end

    // A stalled memory state either keeps counting or aborts back to FETCH;
    // the counter is zero whenever the state moves on or memory answers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = 8'd0;
        illegal_d = 1'b0;
        memerr_d  = 1'b0;
        memWait   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

        if (memWait && !mem_ready) begin
            if (cnt_q == TIMEOUT_LAST) begin
                state_d  = S_FETCH;
                memerr_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                S_FETCH:    state_d = S_DECODE;
                S_DECODE: begin
                    case (Opcode)
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        OP_ADDI:      state_d = S_ADDI_EX;
                        default: begin
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    if (Opcode == OP_SW)
                        state_d = S_MEM_WR;
                    else if (Opcode == OP_LW)
                        state_d = S_MEM_RD;
                    else
                        state_d = S_FETCH;
                end
                S_MEM_RD:   state_d = S_MEM_WB;
                S_MEM_WB:   state_d = S_FETCH;
                S_MEM_WR:   state_d = S_FETCH;
                S_EXEC:     state_d = S_R_WB;
                S_R_WB:     state_d = S_FETCH;
                S_BRANCH:   state_d = S_FETCH;
                S_JUMP:     state_d = S_FETCH;
                S_ADDI_EX:  state_d = S_ADDI_WB;
                S_ADDI_WB:  state_d = S_FETCH;
                default:    state_d = S_FETCH;
            endcase
        end
    end

    // Datapath controls are Moore outputs, except the FETCH loads which wait for memory.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
            end
            default: begin
            end
        endcase

        // Reset must never let a half-finished instruction touch architectural state.
        if (RESET) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
        end
    end

    assign state_out  = state_q;
    assign illegal_op = illegal_q;
    assign mem_err    = memerr_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed-vector bench for multicycle_control_fsm, built with a short memory
// timeout so stall and abort paths are reachable in a few cycles.
module tb_multicycle_control_fsm;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] ILL  = 6'b111111;

    // Control word: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA | ALUSrcB ALUOp PCSource
    localparam logic [15:0] C_FETCH_RDY = 16'b1001010000_01_00_00;
    localparam logic [15:0] C_FETCH_NRD = 16'b0001000000_01_00_00;
    localparam logic [15:0] C_FETCH_RST = 16'b0000000000_01_00_00;
    localparam logic [15:0] C_DECODE    = 16'b0000000000_11_00_00;
    localparam logic [15:0] C_MEM_ADDR  = 16'b0000000001_10_00_00;
    localparam logic [15:0] C_MEM_RD    = 16'b0011000000_00_00_00;
    localparam logic [15:0] C_MEM_RDRST = 16'b0010000000_00_00_00;
    localparam logic [15:0] C_MEM_WB    = 16'b0000001010_00_00_00;
    localparam logic [15:0] C_MEM_WR    = 16'b0010100000_00_00_00;
    localparam logic [15:0] C_EXEC      = 16'b0000000001_00_10_00;
    localparam logic [15:0] C_R_WB      = 16'b0000000110_00_00_00;
    localparam logic [15:0] C_BRANCH    = 16'b0100000001_00_01_01;
    localparam logic [15:0] C_JUMP      = 16'b1000000000_00_00_10;
    localparam logic [15:0] C_ADDI_EX   = 16'b0000000001_10_00_00;
    localparam logic [15:0] C_ADDI_WB   = 16'b0000000010_00_00_00;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [5:0] Opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_out;
    logic       illegal_op, mem_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        ill;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut (
        .CLK(CLK), .RESET(RESET), .Opcode(Opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .state_out(state_out), .illegal_op(illegal_op), .mem_err(mem_err)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mkVec(input logic rst, input logic [5:0] op, input logic rdy,
                                   input logic [3:0] st, input logic [15:0] ctrl,
                                   input logic ill, input logic err);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.ctrl = ctrl; v.ill = ill; v.err = err;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic rdy);
        RESET     = rst;
        Opcode    = op;
        mem_ready = rdy;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] st, input logic [15:0] ctrl,
                               input logic ill, input logic err);
        logic [15:0] actCtrl;
        actCtrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
        checks++;
        if (state_out !== st || actCtrl !== ctrl || illegal_op !== ill || mem_err !== err) begin
            errors++;
            $display("[TB] FAIL %s: got state=%0d ctrl=%b ill=%b err=%b, want state=%0d ctrl=%b ill=%b err=%b",
                     name, state_out, actCtrl, illegal_op, mem_err, st, ctrl, ill, err);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Counts cycles from a FETCH that completes until state_out is back at FETCH.
    task automatic checkCpi(input logic [5:0] op, input int want);
        int cycles;
        applyStimulus(1'b0, op, 1'b1);
        cycles = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (state_out == 4'd0) break;
            cycles++;
        end
        checks++;
        if (cycles != want) begin
            errors++;
            $display("[TB] FAIL cpi op=%b: got %0d cycles, want %0d", op, cycles, want);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset, then lw/R/beq/j/addi back to back with memory always ready.
        vecs.push_back(mkVec(1, RT,   1, 0,  C_FETCH_RST, 0, 0));
        vecs.push_back(mkVec(0, LW,   1, 0,  C_FETCH_RDY, 0, 0));
        vecs.push_back(mkVec(0, LW,   1, 1,  C_DECODE,    0, 0));
        vecs.push_back(mkVec(0, LW,   1, 2,  C_MEM_ADDR,  0, 0));
        vecs.push_back(mkVec(0, LW,   1, 3,  C_MEM_RD,    0, 0));
        vecs.push_back(mkVec(0, LW,   1, 4,  C_MEM_WB,    0, 0));
        vecs.push_back(mkVec(0, RT,   1, 0,  C_FETCH_RDY, 0, 0));
        vecs.push_back(mkVec(0, RT,   1, 1,  C_DECODE,    0, 0));
        vecs.push_back(mkVec(0, RT,   1, 6,  C_EXEC,      0, 0));
        vecs.push_back(mkVec(0, RT,   1, 7,  C_R_WB,      0, 0));
        vecs.push_back(mkVec(0, BEQ,  1, 0,  C_FETCH_RDY, 0, 0));
        vecs.push_back(mkVec(0, BEQ,  1, 1,  C_DECODE,    0, 0));
        vecs.push_back(mkVec(0, BEQ,  1, 8,  C_BRANCH,    0, 0));
        vecs.push_back(mkVec(0, JMP,  1, 0,  C_FETCH_RDY, 0, 0));
        vecs.push_back(mkVec(0, JMP,  1, 1,  C_DECODE,    0, 0));
        vecs.push_back(mkVec(0, JMP,  1, 9,  C_JUMP,      0, 0));
        vecs.push_back(mkVec(0, ADDI, 1, 0,  C_FETCH_RDY, 0, 0));
        vecs.push_back(mkVec(0, ADDI, 1, 1,  C_DECODE,    0, 0));
        vecs.push_back(mkVec(0, ADDI, 1, 10, C_ADDI_EX,   0, 0));
        vecs.push_back(mkVec(0, ADDI, 1, 11, C_ADDI_WB,   0, 0));
        // Illegal opcode: back to FETCH, single-cycle illegal_op pulse.
        vecs.push_back(mkVec(0, ILL,  1, 0,  C_FETCH_RDY, 0, 0));
        vecs.push_back(mkVec(0, ILL,  1, 1,  C_DECODE,    0, 0));
        vecs.push_back(mkVec(0, ILL,  0, 0,  C_FETCH_NRD, 1, 0));
        vecs.push_back(mkVec(0, SW,   1, 0,  C_FETCH_RDY, 0, 0));
        // sw with three stalls; ready arrives exactly at the timeout limit.
        vecs.push_back(mkVec(0, SW,   1, 1,  C_DECODE,    0, 0));
        vecs.push_back(mkVec(0, SW,   1, 2,  C_MEM_ADDR,  0, 0));
        vecs.push_back(mkVec(0, SW,   0, 5,  C_MEM_WR,    0, 0));
        vecs.push_back(mkVec(0, SW,   0, 5,  C_MEM_WR,    0, 0));
        vecs.push_back(mkVec(0, SW,   0, 5,  C_MEM_WR,    0, 0));
        vecs.push_back(mkVec(0, SW,   1, 5,  C_MEM_WR,    0, 0));
        // FETCH timeout after four stalled cycles.
        vecs.push_back(mkVec(0, SW,   0, 0,  C_FETCH_NRD, 0, 0));
        vecs.push_back(mkVec(0, SW,   0, 0,  C_FETCH_NRD, 0, 0));
        vecs.push_back(mkVec(0, SW,   0, 0,  C_FETCH_NRD, 0, 0));
        vecs.push_back(mkVec(0, SW,   0, 0,  C_FETCH_NRD, 0, 0));
        vecs.push_back(mkVec(0, SW,   0, 0,  C_FETCH_NRD, 0, 1));
        vecs.push_back(mkVec(0, SW,   0, 0,  C_FETCH_NRD, 0, 0));
        vecs.push_back(mkVec(0, LW,   1, 0,  C_FETCH_RDY, 0, 0));
        // MEM_RD timeout: abandons the load without MEM_WB.
        vecs.push_back(mkVec(0, LW,   1, 1,  C_DECODE,    0, 0));
        vecs.push_back(mkVec(0, LW,   1, 2,  C_MEM_ADDR,  0, 0));
        vecs.push_back(mkVec(0, LW,   0, 3,  C_MEM_RD,    0, 0));
        vecs.push_back(mkVec(0, LW,   0, 3,  C_MEM_RD,    0, 0));
        vecs.push_back(mkVec(0, LW,   0, 3,  C_MEM_RD,    0, 0));
        vecs.push_back(mkVec(0, LW,   0, 3,  C_MEM_RD,    0, 0));
        vecs.push_back(mkVec(0, LW,   1, 0,  C_FETCH_RDY, 0, 1));
        vecs.push_back(mkVec(0, LW,   1, 1,  C_DECODE,    0, 0));

        applyStimulus(1'b1, RT, 1'b1);
        step();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].rdy);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl, vecs[i].ill, vecs[i].err);
            step();
        end

        // Reset landing in MEM_RD: strobes gated, counter and pulses cleared.
        applyStimulus(1'b0, LW, 1'b1); checkOutput("rst_addr",  4'd2, C_MEM_ADDR,  1'b0, 1'b0); step();
        applyStimulus(1'b0, LW, 1'b0); checkOutput("rst_memrd", 4'd3, C_MEM_RD,    1'b0, 1'b0); step();
        applyStimulus(1'b1, LW, 1'b0); checkOutput("rst_gate",  4'd3, C_MEM_RDRST, 1'b0, 1'b0); step();
        applyStimulus(1'b1, LW, 1'b1); checkOutput("rst_fetch", 4'd0, C_FETCH_RST, 1'b0, 1'b0); step();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, LW, 1'b0);
            checkOutput($sformatf("post_rst_stall%0d", i), 4'd0, C_FETCH_NRD, 1'b0, 1'b0);
            step();
        end
        applyStimulus(1'b0, LW, 1'b0); checkOutput("post_rst_err",  4'd0, C_FETCH_NRD, 1'b0, 1'b1); step();
        applyStimulus(1'b0, LW, 1'b1); checkOutput("post_rst_done", 4'd0, C_FETCH_RDY, 1'b0, 1'b0);

        // Finish that lw from DECODE, then measure CPI per instruction class.
        for (int i = 0; i < 10 && state_out != 4'd0 || i == 0; i++) step();
        checkCpi(LW, 5);
        checkCpi(SW, 4);
        checkCpi(RT, 4);
        checkCpi(ADDI, 4);
        checkCpi(BEQ, 3);
        checkCpi(JMP, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle sequencing controller for the MIPS datapath.
- Replaces single-cycle combinational control with a state machine that drives the shared memory, IR, PC, register file and ALU across several cycles per instruction.
- Adds a memory-ready handshake with timeout and flags illegal opcodes.
- Sits between the instruction register's opcode field and every datapath mux/write-enable.

Parameters:
- MEM_TIMEOUT, 15, consecutive not-ready cycles tolerated in a memory state before abort; legal range 2..255.

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RESET  input  1  synchronous, active-high reset
- Opcode  input  6  Instruction[31:26] from IR
- mem_ready  input  1  memory completes the current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load qualified by ALU zero (datapath ANDs)
- IorD  output  1  0 = memory address from PC, 1 = from ALUOut
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  IR load
- MemtoReg  output  1  write-data select: 0 = ALUOut, 1 = MDR
- RegDst  output  1  write-register select: 0 = rt, 1 = rd
- RegWrite  output  1  register file write enable
- ALUSrcA  output  1  0 = PC, 1 = rs
- ALUSrcB  output  2  00 = rt, 01 = const 4, 10 = signext, 11 = signext<<2
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct decode
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state_out  output  4  current state encoding (debug)
- illegal_op  output  1  registered one-cycle pulse
- mem_err  output  1  registered one-cycle pulse

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11.
- Reset (RESET high at edge): state = FETCH; timeout counter = 0; illegal_op = 0; mem_err = 0.
- While RESET is high, all write/request strobes are forced 0: PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite.
- Reset mid-instruction abandons the instruction with no further writes.
- Outputs are decoded from state. Only IRWrite/PCWrite in FETCH are additionally qualified by mem_ready. Unlisted outputs are 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite = PCWrite = mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute).
  - Next state by Opcode: 100011/101011 -> MEM_ADDR; 000000 -> EXEC; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EX.
  - Any other opcode -> FETCH, and illegal_op pulses high next cycle.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1. Wait for mem_ready, then -> MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEM_WR: MemWrite=1, IorD=1. Wait for mem_ready, then -> FETCH. MemWrite stays held until ready.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- Cycles per instruction with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Timeout counter (8-bit):
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - If the counter equals MEM_TIMEOUT-1 and mem_ready=0: next state = FETCH, counter cleared, mem_err pulses the following cycle. No PC, IR or register write occurs.
  - A FETCH timeout restarts the fetch from the unchanged PC.
  - mem_ready=1 in the same cycle the limit is reached means the access completes normally, with no error.
- Opcode is sampled only in DECODE and MEM_ADDR; it is ignored elsewhere.
- illegal_op and mem_err never assert in the same cycle; each lasts exactly one cycle.
- Unused state codes 12-15 -> FETCH on the next edge, all strobes 0.

Test Plan:
- Reset 2 cycles, then Opcode=100011, mem_ready=1 -> state_out 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. Total 5 cycles.
- Opcode=000000 then 000100 then 000010, mem_ready=1 -> 4, 3, 3 cycles respectively. PCWriteCond=1 only in BRANCH. PCSource=10 with PCWrite=1 in JUMP.
- Opcode=101011, mem_ready low for 3 cycles in MEM_WR -> MemWrite held 4 cycles, IorD=1, then FETCH. No mem_err.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> after 4 cycles state stays/returns FETCH. mem_err=1 for one cycle. PCWrite and IRWrite never 1.
- Opcode=111111 -> DECODE, then FETCH. illegal_op=1 for exactly one cycle. RegWrite, MemWrite and PCWrite stay 0.
- RESET asserted while in MEM_RD -> next state FETCH. All strobes 0 during reset. Counter cleared. No stale mem_err.
